fcvt_sched: RTL and testbench

Round-robin scheduler sharing one float↔int conversion datapath (ftoi `fcvt.w.s` and itof `fcvt.s.w`) between `NREQ` requesters, typically the integer and FP issue ports of the core. It arbitrates with valid/ready handshakes and runs a 2-stage pipeline with the converters between the stages. Each result returns on a single response port tagged with the requester's id and tag. Throughput is one conversion per cycle.

---
 rtl/fcvt_pkg.sv | 13 +
 rtl/fcvt_ftoi.sv | 31 +++
 rtl/fcvt_itof.sv | 33 +++
 rtl/fcvt_rr_arbiter.sv | 45 ++++
 rtl/fcvt_sched.sv | 134 +++++++++++++
 tb/tb_fcvt_sched.sv | 272 +++++++++++++++++++++++++++
 6 files changed

// File: rtl/fcvt_pkg.sv
// Shared types and constants for the float<->int conversion scheduler.
package fcvt_pkg;

  typedef enum logic {
    OP_FTOI = 1'b0,
    OP_ITOF = 1'b1
  } fcvt_op_t;

  localparam int unsigned FCVT_W     = 32;
  // 127 bias + 30: the exponent at which the top mantissa bit lands on bit 30
  localparam int unsigned FTOI_EBIAS = 157;

endpackage

// File: rtl/fcvt_ftoi.sv
// Combinational fcvt.w.s: single-precision float to signed 32-bit integer,
// round to nearest with ties away from zero.
module fcvt_ftoi
  import fcvt_pkg::*;
(
  input  logic [FCVT_W-1:0] src,
  output logic [FCVT_W-1:0] res
);

  logic              sgn;
  logic [7:0]        expo;
  logic [7:0]        sh;
  logic [22:0]       man;
  logic [FCVT_W-1:0] aligned;
  logic [FCVT_W-1:0] shifted;
  logic [FCVT_W-1:0] mag;

  // Align the significand so bit 0 is the half-ulp, add it, then drop it.
  // Shift amounts above 31 (tiny inputs) flush the operand to zero.
  always_comb begin
    sgn     = src[31];
    expo    = src[30:23];
    man     = src[22:0];
    aligned = {1'b1, man, 8'b0};
    sh      = 8'(FTOI_EBIAS) - expo;
    shifted = aligned >> sh;
    mag     = (shifted + 32'd1) >> 1;
    res     = sgn ? (~mag + 32'd1) : mag;
  end

endmodule

// File: rtl/fcvt_itof.sv
// Combinational fcvt.s.w: signed 32-bit integer to single-precision float,
// round to nearest with ties away from zero.
module fcvt_itof
  import fcvt_pkg::*;
(
  input  logic [FCVT_W-1:0] src,
  output logic [FCVT_W-1:0] res
);

  logic              sgn;
  logic [FCVT_W-1:0] mag;
  logic [FCVT_W-1:0] norm;
  logic [4:0]        lz;
  logic [23:0]       rnd;
  logic [7:0]        expo;

  // Normalize by leading-zero count, round on the first dropped bit, and
  // fold a mantissa carry-out into the exponent.
  always_comb begin
    sgn = src[31];
    mag = sgn ? (~src + 32'd1) : src;
    lz  = 5'd31;
    for (int i = 0; i < 32; i++) begin
      if (mag[i]) lz = 5'(31 - i);
    end
    norm = mag << lz;
    rnd  = {1'b0, norm[30:8]} + 24'(norm[7]);
    expo = 8'd158 - {3'b0, lz} + {7'b0, rnd[23]};
    // norm[31] is clear only for a zero operand
    res  = norm[31] ? {sgn, expo, rnd[22:0]} : '0;
  end

endmodule

// File: rtl/fcvt_rr_arbiter.sv
// Round-robin arbiter: searches upward from rr, wrapping, and moves rr just
// past the winner whenever a grant is taken.
module fcvt_rr_arbiter #(
  parameter  int unsigned NREQ = 2,
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx
);

  logic [IDW-1:0] rr;
  logic           found;
  int unsigned    cand;

  // First requester at or above rr, modulo NREQ.
  always_comb begin
    grant     = '0;
    grant_idx = rr;
    found     = 1'b0;
    cand      = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = 32'(rr) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!found && req[IDW'(cand)]) begin
        found                = 1'b1;
        grant[IDW'(cand)]    = 1'b1;
        grant_idx            = IDW'(cand);
      end
    end
  end

  // Pointer moves past the winner only when the grant is consumed.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr <= '0;
    end else if (advance && found) begin
      rr <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
    end
  end

endmodule

// File: rtl/fcvt_sched.sv
// Shares one ftoi/itof datapath among NREQ requesters through a round-robin
// arbiter and a two-stage pipeline with the converters between the stages.
module fcvt_sched
  import fcvt_pkg::*;
#(
  parameter  int unsigned NREQ = 2,
  parameter  int unsigned TAGW = 5,
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ-1:0]        req_op,
  input  logic [NREQ*FCVT_W-1:0] req_src,
  input  logic [NREQ*TAGW-1:0]   req_tag,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [FCVT_W-1:0]      resp_data,
  output logic [TAGW-1:0]        resp_tag,
  output logic [IDW-1:0]         resp_id,
  output logic                   busy
);

  typedef struct packed {
    fcvt_op_t          op;
    logic [FCVT_W-1:0] src;
    logic [TAGW-1:0]   tag;
    logic [IDW-1:0]    id;
  } s1_t;

  typedef struct packed {
    logic [FCVT_W-1:0] data;
    logic [TAGW-1:0]   tag;
    logic [IDW-1:0]    id;
  } s2_t;

  logic              s1_valid;
  logic              s2_valid;
  s1_t               s1_q;
  s1_t               s1_d;
  s2_t               s2_q;
  logic              s1_adv;
  logic              s2_adv;
  logic              accept;
  logic [NREQ-1:0]   grant;
  logic [IDW-1:0]    grant_idx;
  logic [FCVT_W-1:0] ftoi_res;
  logic [FCVT_W-1:0] itof_res;
  logic [FCVT_W-1:0] cvt_res;

  fcvt_rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .clk       (clk),
    .rstn      (rstn),
    .req       (req_valid),
    .advance   (s1_adv),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Pipeline advance; ready is gated by rstn so it drops during reset.
  always_comb begin
    s2_adv    = !s2_valid || resp_ready;
    s1_adv    = !s1_valid || s2_adv;
    req_ready = grant & {NREQ{s1_adv & rstn}};
    accept    = |(req_valid & req_ready);
  end

  // Payload of the granted requester; one-hot grant keeps this a plain AND-OR.
  always_comb begin
    s1_d     = '0;
    s1_d.id  = grant_idx;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        s1_d.op  = fcvt_op_t'(req_op[i]);
        s1_d.src = req_src[i*FCVT_W +: FCVT_W];
        s1_d.tag = req_tag[i*TAGW +: TAGW];
      end
    end
  end

  fcvt_ftoi u_ftoi (
    .src (s1_q.src),
    .res (ftoi_res)
  );

  fcvt_itof u_itof (
    .src (s1_q.src),
    .res (itof_res)
  );

  // Converter select.
  always_comb begin
    cvt_res = (s1_q.op == OP_ITOF) ? itof_res : ftoi_res;
  end

  // Stage 1: captures the accepted request.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (s1_adv) begin
      s1_valid <= accept;
      if (accept) s1_q <= s1_d;
    end
  end

  // Stage 2: captures the converted result; empties when S1 is empty.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s2_valid <= 1'b0;
      s2_q     <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_q.data <= cvt_res;
        s2_q.tag  <= s1_q.tag;
        s2_q.id   <= s1_q.id;
      end
    end
  end

  // Response port driven straight from the S2 flops.
  always_comb begin
    resp_valid = s2_valid;
    resp_data  = s2_q.data;
    resp_tag   = s2_q.tag;
    resp_id    = s2_q.id;
    busy       = s1_valid | s2_valid;
  end

endmodule

// File: tb/tb_fcvt_sched.sv
// Scoreboard bench for fcvt_sched: accepted requests push expected results,
// a monitor pops and compares each delivered response.
module tb_fcvt_sched;

  localparam int unsigned NREQ = 2;
  localparam int unsigned TAGW = 5;
  localparam bit FT = 1'b0;
  localparam bit IT = 1'b1;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  tag;
    logic [0:0]  id;
  } exp_t;

  logic         clk;
  logic         rstn;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [1:0]   req_op;
  logic [63:0]  req_src;
  logic [9:0]   req_tag;
  logic         resp_valid;
  logic         resp_ready;
  logic [31:0]  resp_data;
  logic [4:0]   resp_tag;
  logic [0:0]   resp_id;
  logic         busy;

  logic [31:0]  exp_data [2];
  exp_t         sb [$];
  exp_t         acc_e;
  exp_t         mon_e;
  int           total;
  int           bad;

  fcvt_sched #(
    .NREQ (NREQ),
    .TAGW (TAGW)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_src    (req_src),
    .req_tag    (req_tag),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_tag   (resp_tag),
    .resp_id    (resp_id),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  // Expected response recorded at the moment a request is accepted.
  always @(negedge clk) begin
    if (rstn) begin
      for (int i = 0; i < 2; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          acc_e.data = exp_data[i];
          acc_e.tag  = req_tag[5*i +: 5];
          acc_e.id   = 1'(i);
          sb.push_back(acc_e);
        end
      end
    end
  end

  // Response monitor.
  always @(negedge clk) begin
    if (rstn && resp_valid && resp_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_resp: got data %h tag %0d want none", resp_data, resp_tag);
      end else begin
        mon_e = sb.pop_front();
        chk("resp_data", resp_data, mon_e.data);
        chk("resp_tag", 32'(resp_tag), 32'(mon_e.tag));
        chk("resp_id", 32'(resp_id), 32'(mon_e.id));
      end
    end
  end

  task automatic set_req(input int i, input bit op, input logic [31:0] src,
                         input logic [4:0] tag, input logic [31:0] want);
    req_valid[i]        = 1'b1;
    req_op[i]           = op;
    req_src[32*i +: 32] = src;
    req_tag[5*i +: 5]   = tag;
    exp_data[i]         = want;
  endtask

  task automatic wait_accept(input int i);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      if (req_valid[i] && req_ready[i]) ok = 1'b1;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL accept_timeout: got no accept want accept on req %0d", i);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int i, input bit op, input logic [31:0] src,
                       input logic [4:0] tag, input logic [31:0] want);
    set_req(i, op, src, tag, want);
    wait_accept(i);
    req_valid[i] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want test done");
    $fatal(1);
  end

  initial begin
    total      = 0;
    bad        = 0;
    rstn       = 1'b0;
    req_valid  = 2'b11;
    req_op     = 2'b00;
    req_src    = {32'h40200000, 32'h40200000};
    req_tag    = {5'd9, 5'd9};
    resp_ready = 1'b1;
    exp_data[0] = 32'h0;
    exp_data[1] = 32'h0;

    // reset state, with requests pending
    #12;
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_resp_data", resp_data, 32'h0);
    chk("rst_resp_tag", 32'(resp_tag), 32'h0);
    chk("rst_resp_id", 32'(resp_id), 32'h0);
    req_valid = 2'b00;
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // single ftoi with latency check
    issue(0, FT, 32'h40200000, 5'd3, 32'd3);
    chk("lat_c1_valid", 32'(resp_valid), 32'h0);
    @(posedge clk);
    #1;
    chk("lat_c2_valid", 32'(resp_valid), 32'h1);
    issue(0, FT, 32'hBFC00000, 5'd4, 32'hFFFFFFFE);
    idle(4);

    // itof values from requester 1
    issue(1, IT, 32'd7, 5'd11, 32'h40E00000);
    issue(1, IT, 32'hFFFFFFFF, 5'd12, 32'hBF800000);
    issue(1, IT, 32'h01000001, 5'd13, 32'h4B800001);
    issue(1, IT, 32'h00000000, 5'd14, 32'h00000000);
    idle(4);

    // contention: rr is back at 0 after requester 1 won last
    set_req(0, FT, 32'h40200000, 5'd10, 32'd3);
    set_req(1, IT, 32'd7, 5'd20, 32'h40E00000);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rr_grant", 32'(req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
      if (k >= 2) begin
        chk("rr_resp_valid", 32'(resp_valid), 32'h1);
        chk("rr_resp_id", 32'(resp_id), 32'(k % 2));
      end
      @(posedge clk);
      #1;
      req_tag[4:0] = 5'(11 + k);
      req_tag[9:5] = 5'(21 + k);
    end
    req_valid = 2'b00;
    idle(4);

    // backpressure: hold the first response for 4 cycles
    set_req(1, IT, 32'd7, 5'd1, 32'h40E00000);
    @(negedge clk);
    chk("bp_acc_a", 32'(req_ready), 32'h2);
    @(posedge clk);
    #1;
    set_req(1, IT, 32'hFFFFFFFF, 5'd2, 32'hBF800000);
    @(negedge clk);
    chk("bp_acc_b", 32'(req_ready), 32'h2);
    @(posedge clk);
    #1;
    set_req(1, FT, 32'h40200000, 5'd3, 32'd3);
    resp_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_valid", 32'(resp_valid), 32'h1);
      chk("bp_data", resp_data, 32'h40E00000);
      chk("bp_tag", 32'(resp_tag), 32'd1);
      chk("bp_req_ready", 32'(req_ready), 32'h0);
      @(posedge clk);
      #1;
    end
    resp_ready = 1'b1;
    wait_accept(1);
    req_valid = 2'b00;
    idle(5);
    chk("bp_sb_empty", 32'(sb.size()), 32'h0);

    // reset mid-flight with both stages full
    resp_ready = 1'b0;
    set_req(0, FT, 32'h40200000, 5'd5, 32'd3);
    set_req(1, IT, 32'd7, 5'd6, 32'h40E00000);
    idle(3);
    chk("pre_rst_busy", 32'(busy), 32'h1);
    chk("pre_rst_valid", 32'(resp_valid), 32'h1);
    @(negedge clk);
    #2;
    rstn = 1'b0;
    sb.delete();
    #1;
    chk("mid_rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_req_ready", 32'(req_ready), 32'h0);
    @(negedge clk);
    req_valid  = 2'b00;
    resp_ready = 1'b1;
    rstn       = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stale_resp", 32'(resp_valid), 32'h0);
      chk("stale_busy", 32'(busy), 32'h0);
    end
    @(posedge clk);
    #1;
    set_req(0, FT, 32'hBFC00000, 5'd7, 32'hFFFFFFFE);
    set_req(1, IT, 32'h00000000, 5'd8, 32'h00000000);
    @(negedge clk);
    chk("post_rst_grant", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    wait_accept(1);
    req_valid = 2'b00;
    idle(5);
    chk("end_sb_empty", 32'(sb.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
